transpose_row_feeder: RTL and testbench
=======================================

# transpose_row_feeder

Upstream transmitter for the matrix-transpose write port. Accepts a scalar element stream with valid/ready handshake and packs NUM_PE elements into one row vector. Emits rows to the transpose engine with row_val, honouring the engine's one-cycle bank-swap gap after every NUM_PE-th row. Zero-pads a matrix that is terminated early by in_last, so the engine always receives complete NUM_PE x NUM_PE matrices.

## Interface
- DATA_WIDTH, 64, element width in bits
- NUM_PE, 8, elements per row and rows per matrix (power of two, >= 2)
- ROW_WIDTH, DATA_WIDTH*NUM_PE, derived; not to be overridden
- IDX_BITS, $clog2(NUM_PE), derived
- clk  in  1  clock
- rst  in  1  reset: rst, synchronous, active-high; clock clk
- in_valid  in  1  upstream element valid
- in_ready  out  1  element accepted on in_valid && in_ready
- in_data  in  DATA_WIDTH  element value
- in_last  in  1  final element of the current matrix; sampled only on handshake
- row_val  out  1  row_data holds a row the engine must write this cycle (no back-pressure)
- row_data  out  ROW_WIDTH  packed row; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- row_idx  out  IDX_BITS  row number within the matrix, valid when row_val
- mat_done  out  1  one-cycle pulse: a full matrix has been emitted
- busy  out  1  any element, row or pad/gap work outstanding

## Operation
- Input side, states FILL and PAD; counters in_col, in_row (IDX_BITS each); row assembly register.
- FILL: each handshake writes in_data into element slot in_col, in_col++. On the slot NUM_PE-1 handshake the assembled row is pushed into the row FIFO, in_col <= 0, in_row++ (wraps at NUM_PE).
- Accepted element in_col==0 of a row: the slots it does not write are zero; no stale data from earlier rows may appear.
- in_ready = (state==FILL) && !(in_col==NUM_PE-1 && fifo_full). Same-cycle pop is not credited.
- in_last on element (in_row==NUM_PE-1, in_col==NUM_PE-1): normal completion, stay FILL.
- in_last anywhere else: current row pushed with unwritten slots zero, then PAD.
- PAD: in_ready=0; push one all-zero row per cycle while FIFO not full until NUM_PE rows total have been pushed for the matrix; then in_row <= 0, in_col <= 0, FILL.
- Row FIFO: 2 entries of ROW_WIDTH, registered storage, first-word-fall-through.
- Output side, states SEND and GAP; counter out_row (IDX_BITS).
- SEND: row_val = FIFO not empty; row_data = FIFO head; row_idx = out_row; head popped every cycle row_val=1. If out_row==NUM_PE-1 on a pop: out_row <= 0, go GAP; else out_row++.
- GAP: exactly one cycle, row_val=0 regardless of FIFO contents, mat_done=1; return to SEND.
- busy = FIFO not empty || in_col!=0 || in_row!=0 || PAD || GAP.

## Timing
- Reset: FILL/SEND, all counters 0, FIFO empty. row_val=0, row_idx=0, mat_done=0, busy=0; in_ready=1 from the first cycle after reset.
- Reset mid-operation: partial row, FIFO contents and pad work discarded; row_val low from the edge rst is sampled; next accepted element is matrix row 0 slot 0.
- Latency: handshake of a row's last element in cycle t -> row_val with that row in cycle t+1 when the FIFO was empty and the output is in SEND.
- GAP cycle immediately follows the row_idx==NUM_PE-1 beat; mat_done is high in that GAP cycle only.
- Sustained input of 1 element/cycle: never stalls; rows emerge one per NUM_PE cycles.
- Pad rows: one push per cycle; output drains one per cycle except the GAP cycle.
- FIFO full and in_col==NUM_PE-1: in_ready low until a pop has registered.
- in_last with in_valid low or in_ready low is ignored.

## Test plan
- 64 elements 0..63 back-to-back, in_last on 63 -> 8 row_val beats, row r element k = 8r+k, row_idx 0..7, GAP + mat_done one cycle after row 7, in_ready never low.
- in_last on element 19 -> row 2 = {16,17,18,19,0,0,0,0}, rows 3..7 all zero, in_ready low during PAD, then element 0 of next matrix appears in row_idx 0.
- in_last on element 0 -> row 0 = {x,0,...,0}, rows 1..7 zero; exactly 8 beats, one mat_done.
- Random in_valid idle cycles over 128 elements (two matrices) -> row contents identical to back-to-back case; exactly one row_val per completed row, two mat_done pulses.
- rst asserted after 20 accepted elements -> no further row_val; subsequent 64-element matrix emitted from row_idx 0 with correct data.
- Early in_last at element 3 immediately followed by new matrix in_valid -> pad rows fill FIFO, in_ready low until FILL resumes, GAP cycle still exactly one cycle after pad row 7.

Source files
------------

// File: rtl/transpose_row_feeder_if.sv
// Handshake/bus bundle for transpose_row_feeder.
//   in_valid/in_ready/in_data/in_last : scalar element stream from upstream
//   row_val/row_data/row_idx          : row beats to the transpose engine (no back-pressure)
//   mat_done                          : one-cycle pulse after the last row of a matrix
//   busy                              : feeder has outstanding element/row/pad/gap work
// Modports: master = upstream/engine side (bench), slave = the feeder itself.
interface transpose_row_feeder_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8
);
  localparam int ROW_WIDTH = DATA_WIDTH * NUM_PE;
  localparam int IDX_BITS  = $clog2(NUM_PE);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_last;
  logic                  row_val;
  logic [ROW_WIDTH-1:0]  row_data;
  logic [IDX_BITS-1:0]   row_idx;
  logic                  mat_done;
  logic                  busy;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, row_val, row_data, row_idx, mat_done, busy
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, row_val, row_data, row_idx, mat_done, busy
  );
endinterface

// File: rtl/transpose_row_feeder.sv
// Packs a scalar element stream into NUM_PE-wide rows for the transpose engine.
// Matrices cut short by in_last are zero-padded to NUM_PE rows, and one idle
// (GAP) cycle follows every NUM_PE-th row so the engine can swap banks.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : transpose_row_feeder_if.slave (element input, row output, status)
module transpose_row_feeder #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_PE     = 8,
  parameter int ROW_WIDTH  = DATA_WIDTH * NUM_PE,
  parameter int IDX_BITS   = $clog2(NUM_PE)
) (
  input  logic                     clk,
  input  logic                     rst,
  transpose_row_feeder_if.slave    bus
);

  typedef enum logic {FILL = 1'b0, PAD  = 1'b1} in_state_e;
  typedef enum logic {SEND = 1'b0, GAP  = 1'b1} out_state_e;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_PE - 1);

  // input side
  in_state_e                             in_state_q, in_state_d;
  logic [IDX_BITS-1:0]                   in_col_q, in_col_d;
  logic [IDX_BITS-1:0]                   in_row_q, in_row_d;
  logic [NUM_PE-1:0][DATA_WIDTH-1:0]     asm_q, asm_d, asm_wr;

  // row FIFO (2 entries, first-word-fall-through)
  logic [1:0][ROW_WIDTH-1:0]             mem_q;
  logic                                  wr_ptr_q, wr_ptr_d;
  logic                                  rd_ptr_q, rd_ptr_d;
  logic [1:0]                            cnt_q, cnt_d;
  logic                                  fifo_full, fifo_empty;
  logic                                  push, pop;
  logic [ROW_WIDTH-1:0]                  push_row;

  // output side
  out_state_e                            out_state_q, out_state_d;
  logic [IDX_BITS-1:0]                   out_row_q, out_row_d;

  logic                                  in_ready, hs;

  assign fifo_full  = (cnt_q == 2'd2);
  assign fifo_empty = (cnt_q == 2'd0);

  // A pop in the same cycle is deliberately not credited: keeps in_ready off
  // the output path.
  assign in_ready = (in_state_q == FILL) && !(in_col_q == LAST_IDX && fifo_full);
  assign hs       = bus.in_valid && in_ready;

  // Input FSM: assembly, early-termination and padding
  always_comb begin
    in_state_d = in_state_q;
    in_col_d   = in_col_q;
    in_row_d   = in_row_q;
    asm_d      = asm_q;
    push       = 1'b0;
    push_row   = '0;
    asm_wr            = asm_q;
    asm_wr[in_col_q]  = bus.in_data;

    case (in_state_q)
      FILL: begin
        if (hs) begin
          if (in_col_q == LAST_IDX) begin
            // Full row; in_ready guarantees FIFO space here.
            push     = 1'b1;
            push_row = asm_wr;
            asm_d    = '0;
            in_col_d = '0;
            in_row_d = in_row_q + IDX_BITS'(1);
            if (bus.in_last && in_row_q != LAST_IDX) in_state_d = PAD;
          end else if (bus.in_last) begin
            // Early end mid-row. Push now if there is room, otherwise park the
            // partial row in asm and let PAD push it as its first row.
            if (!fifo_full) begin
              push     = 1'b1;
              push_row = asm_wr;
              asm_d    = '0;
              in_col_d = '0;
              in_row_d = in_row_q + IDX_BITS'(1);
              // Nothing left to pad when this was already the matrix's last row.
              if (in_row_q != LAST_IDX) in_state_d = PAD;
            end else begin
              asm_d      = asm_wr;
              in_state_d = PAD;
            end
          end else begin
            asm_d    = asm_wr;
            in_col_d = in_col_q + IDX_BITS'(1);
          end
        end
      end
      PAD: begin
        // asm is all-zero except possibly the parked partial row on entry.
        if (!fifo_full) begin
          push     = 1'b1;
          push_row = asm_q;
          asm_d    = '0;
          in_col_d = '0;
          if (in_row_q == LAST_IDX) begin
            in_row_d   = '0;
            in_state_d = FILL;
          end else begin
            in_row_d = in_row_q + IDX_BITS'(1);
          end
        end
      end
      default: in_state_d = FILL;
    endcase
  end

  // Output FSM: row beats and the post-matrix gap
  always_comb begin
    out_state_d = out_state_q;
    out_row_d   = out_row_q;
    pop         = 1'b0;
    case (out_state_q)
      SEND: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (out_row_q == LAST_IDX) begin
            out_row_d   = '0;
            out_state_d = GAP;
          end else begin
            out_row_d = out_row_q + IDX_BITS'(1);
          end
        end
      end
      GAP:     out_state_d = SEND;
      default: out_state_d = SEND;
    endcase
  end

  // FIFO pointer/count update
  always_comb begin
    wr_ptr_d = push ? !wr_ptr_q : wr_ptr_q;
    rd_ptr_d = pop  ? !rd_ptr_q : rd_ptr_q;
    cnt_d    = cnt_q + 2'(push) - 2'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_state_q  <= FILL;
      in_col_q    <= '0;
      in_row_q    <= '0;
      asm_q       <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      cnt_q       <= 2'd0;
      out_state_q <= SEND;
      out_row_q   <= '0;
    end else begin
      in_state_q  <= in_state_d;
      in_col_q    <= in_col_d;
      in_row_q    <= in_row_d;
      asm_q       <= asm_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      out_state_q <= out_state_d;
      out_row_q   <= out_row_d;
    end
  end

  // Storage needs no reset: it is only observed through row_val.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_row;
  end

  assign bus.in_ready = in_ready;
  assign bus.row_val  = (out_state_q == SEND) && !fifo_empty;
  assign bus.row_data = mem_q[rd_ptr_q];
  assign bus.row_idx  = out_row_q;
  assign bus.mat_done = (out_state_q == GAP);
  assign bus.busy     = !fifo_empty || (in_col_q != '0) || (in_row_q != '0) ||
                        (in_state_q == PAD) || (out_state_q == GAP);

endmodule

// File: tb/tb_transpose_row_feeder.sv
module tb_transpose_row_feeder;
  localparam int DW = 16;
  localparam int NP = 8;
  localparam int RW = DW * NP;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  transpose_row_feeder_if #(.DATA_WIDTH(DW), .NUM_PE(NP)) bus();
  transpose_row_feeder #(.DATA_WIDTH(DW), .NUM_PE(NP)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int stalls = 0;
  int hs_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Row monitor (sole writer of these records)
  logic [RW-1:0] beat_data[$];
  int            beat_idx[$];
  int            beat_cyc[$];
  int            md_cnt   = 0;
  int            gap_viol = 0;
  bit            prev7    = 1'b0;

  always @(negedge clk) begin
    if (rst) prev7 = 1'b0;
    else begin
      if (bus.row_val) begin
        beat_data.push_back(bus.row_data);
        beat_idx.push_back(int'(bus.row_idx));
        beat_cyc.push_back(cyc);
      end
      if (bus.mat_done) md_cnt++;
      if (prev7 && (!bus.mat_done || bus.row_val)) gap_viol++;
      if (bus.mat_done && !prev7) gap_viol++;
      prev7 = bus.row_val && (bus.row_idx == 3'(NP - 1));
    end
  end

  function automatic logic [RW-1:0] mk(int base, int n);
    logic [RW-1:0] r;
    r = '0;
    for (int k = 0; k < n; k++) r[k*DW +: DW] = DW'(base + k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input int d, input bit last);
    bit ok, got;
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    bus.in_last  = last;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      ok = bus.in_ready;
      tick();
      if (ok) got = 1'b1; else stalls++;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL send_timeout: element %0d not accepted within 100 cycles", d);
    end
    hs_cyc = cyc;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain();
    int i;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    i = 0;
    while (bus.busy && i < 300) begin tick(); i++; end
    if (i >= 300) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: busy still high after 300 cycles");
    end
    idle(3);
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_last = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (bus.row_val  !== 1'b0) begin n_err++; $display("FAIL rst_row_val: got %b want 0", bus.row_val); end
    n_cmp++; if (bus.row_idx  !== 3'd0) begin n_err++; $display("FAIL rst_row_idx: got %0d want 0", bus.row_idx); end
    n_cmp++; if (bus.mat_done !== 1'b0) begin n_err++; $display("FAIL rst_mat_done: got %b want 0", bus.mat_done); end
    n_cmp++; if (bus.busy     !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_back_to_back();
    int b, m, g, h7;
    b = beat_data.size(); m = md_cnt; g = gap_viol; stalls = 0; h7 = 0;
    for (int i = 0; i < 64; i++) begin
      send(i, i == 63);
      if (i == 7) h7 = hs_cyc;
    end
    drain();
    n_cmp++; if (beat_data.size() - b != 8) begin n_err++; $display("FAIL b2b_beats: got %0d want 8", beat_data.size() - b); end
    for (int r = 0; r < 8 && b + r < beat_data.size(); r++) begin
      n_cmp++; if (beat_data[b+r] !== mk(8*r, 8)) begin n_err++; $display("FAIL b2b_row%0d: got %h want %h", r, beat_data[b+r], mk(8*r, 8)); end
      n_cmp++; if (beat_idx[b+r] != r) begin n_err++; $display("FAIL b2b_idx%0d: got %0d want %0d", r, beat_idx[b+r], r); end
    end
    if (b < beat_data.size()) begin
      n_cmp++; if (beat_cyc[b] != h7) begin n_err++; $display("FAIL b2b_latency: got cycle %0d want %0d", beat_cyc[b], h7); end
    end
    n_cmp++; if (md_cnt - m != 1) begin n_err++; $display("FAIL b2b_mat_done: got %0d want 1", md_cnt - m); end
    n_cmp++; if (gap_viol - g != 0) begin n_err++; $display("FAIL b2b_gap: got %0d violations want 0", gap_viol - g); end
    n_cmp++; if (stalls != 0) begin n_err++; $display("FAIL b2b_stalls: got %0d want 0", stalls); end
  endtask

  task automatic test_early_last_19();
    int b, m;
    logic [RW-1:0] exp_r[16];
    b = beat_data.size(); m = md_cnt;
    for (int i = 0; i < 20; i++) send(i, i == 19);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL e19_pad_ready: got %b want 0", bus.in_ready); end
    send(16'h55, 1'b1);
    drain();
    for (int r = 0; r < 16; r++) exp_r[r] = '0;
    exp_r[0] = mk(0, 8); exp_r[1] = mk(8, 8); exp_r[2] = mk(16, 4); exp_r[8] = mk(16'h55, 1);
    n_cmp++; if (beat_data.size() - b != 16) begin n_err++; $display("FAIL e19_beats: got %0d want 16", beat_data.size() - b); end
    for (int r = 0; r < 16 && b + r < beat_data.size(); r++) begin
      n_cmp++; if (beat_data[b+r] !== exp_r[r] || beat_idx[b+r] != r % 8) begin
        n_err++; $display("FAIL e19_row%0d: got %h idx %0d want %h idx %0d", r, beat_data[b+r], beat_idx[b+r], exp_r[r], r % 8);
      end
    end
    n_cmp++; if (md_cnt - m != 2) begin n_err++; $display("FAIL e19_mat_done: got %0d want 2", md_cnt - m); end
  endtask

  task automatic test_last_first();
    int b, m;
    logic [RW-1:0] want;
    b = beat_data.size(); m = md_cnt;
    send(16'h1234, 1'b1);
    drain();
    n_cmp++; if (beat_data.size() - b != 8) begin n_err++; $display("FAIL l0_beats: got %0d want 8", beat_data.size() - b); end
    for (int r = 0; r < 8 && b + r < beat_data.size(); r++) begin
      want = (r == 0) ? mk(16'h1234, 1) : '0;
      n_cmp++; if (beat_data[b+r] !== want || beat_idx[b+r] != r) begin
        n_err++; $display("FAIL l0_row%0d: got %h idx %0d want %h idx %0d", r, beat_data[b+r], beat_idx[b+r], want, r);
      end
    end
    n_cmp++; if (md_cnt - m != 1) begin n_err++; $display("FAIL l0_mat_done: got %0d want 1", md_cnt - m); end
  endtask

  task automatic test_idle_gaps();
    int b, m, g;
    b = beat_data.size(); m = md_cnt; g = gap_viol;
    for (int i = 0; i < 128; i++) begin
      send(i, i == 63 || i == 127);
      // in_last toggled high while in_valid is low must be ignored
      bus.in_last = 1'b1;
      idle(i % 3);
    end
    drain();
    n_cmp++; if (beat_data.size() - b != 16) begin n_err++; $display("FAIL idle_beats: got %0d want 16", beat_data.size() - b); end
    for (int r = 0; r < 16 && b + r < beat_data.size(); r++) begin
      n_cmp++; if (beat_data[b+r] !== mk(8*r, 8) || beat_idx[b+r] != r % 8) begin
        n_err++; $display("FAIL idle_row%0d: got %h idx %0d want %h idx %0d", r, beat_data[b+r], beat_idx[b+r], mk(8*r, 8), r % 8);
      end
    end
    n_cmp++; if (md_cnt - m != 2) begin n_err++; $display("FAIL idle_mat_done: got %0d want 2", md_cnt - m); end
    n_cmp++; if (gap_viol - g != 0) begin n_err++; $display("FAIL idle_gap: got %0d violations want 0", gap_viol - g); end
  endtask

  task automatic test_reset_mid();
    int b, m;
    for (int i = 0; i < 20; i++) send(i, 1'b0);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b = beat_data.size();
    idle(10);
    n_cmp++; if (beat_data.size() - b != 0) begin n_err++; $display("FAIL rmid_no_rows: got %0d beats want 0", beat_data.size() - b); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", bus.busy); end
    b = beat_data.size(); m = md_cnt;
    for (int i = 0; i < 64; i++) send(100 + i, i == 63);
    drain();
    n_cmp++; if (beat_data.size() - b != 8) begin n_err++; $display("FAIL rmid_beats: got %0d want 8", beat_data.size() - b); end
    for (int r = 0; r < 8 && b + r < beat_data.size(); r++) begin
      n_cmp++; if (beat_data[b+r] !== mk(100 + 8*r, 8) || beat_idx[b+r] != r) begin
        n_err++; $display("FAIL rmid_row%0d: got %h idx %0d want %h idx %0d", r, beat_data[b+r], beat_idx[b+r], mk(100 + 8*r, 8), r);
      end
    end
    n_cmp++; if (md_cnt - m != 1) begin n_err++; $display("FAIL rmid_mat_done: got %0d want 1", md_cnt - m); end
  endtask

  task automatic test_early3_back_to_back();
    int b, m, g, st0;
    logic [RW-1:0] want;
    b = beat_data.size(); m = md_cnt; g = gap_viol;
    for (int i = 0; i < 4; i++) send(i, i == 3);
    stalls = 0;
    send(200, 1'b0);
    st0 = stalls;
    for (int i = 1; i < 64; i++) send(200 + i, i == 63);
    drain();
    // seven pad rows at one push per cycle hold off the next matrix
    n_cmp++; if (st0 != 7) begin n_err++; $display("FAIL e3_pad_stalls: got %0d want 7", st0); end
    n_cmp++; if (beat_data.size() - b != 16) begin n_err++; $display("FAIL e3_beats: got %0d want 16", beat_data.size() - b); end
    for (int r = 0; r < 16 && b + r < beat_data.size(); r++) begin
      if (r == 0)     want = mk(0, 4);
      else if (r < 8) want = '0;
      else            want = mk(200 + 8*(r - 8), 8);
      n_cmp++; if (beat_data[b+r] !== want || beat_idx[b+r] != r % 8) begin
        n_err++; $display("FAIL e3_row%0d: got %h idx %0d want %h idx %0d", r, beat_data[b+r], beat_idx[b+r], want, r % 8);
      end
    end
    n_cmp++; if (md_cnt - m != 2) begin n_err++; $display("FAIL e3_mat_done: got %0d want 2", md_cnt - m); end
    n_cmp++; if (gap_viol - g != 0) begin n_err++; $display("FAIL e3_gap: got %0d violations want 0", gap_viol - g); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_early_last_19();
    test_last_first();
    test_idle_gaps();
    test_reset_mid();
    test_early3_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
